// File: rtl/rns_reverse_converter_pipe_if.sv
// Residue-triple input channel and binary result output channel.
// Latency: none (signal bundle only).
// Backpressure: in_ready / out_ready valid-ready handshakes.
//
// Port summary:
//   in_valid/in_ready   input handshake; x1 (N+1b), x2 (Nb), x3 (Nb) residues
//   out_valid/out_ready output handshake; out (3N b) binary result, out_err flag
//   master: producer/consumer side, slave: converter side
interface rns_reverse_converter_pipe_if #(parameter int N = 3);
    logic           in_valid;
    logic           in_ready;
    logic [N:0]     x1;
    logic [N-1:0]   x2;
    logic [N-1:0]   x3;
    logic           out_valid;
    logic           out_ready;
    logic [3*N-1:0] out;
    logic           out_err;

    modport master (
        output in_valid, x1, x2, x3, out_ready,
        input  in_ready, out_valid, out, out_err
    );

    modport slave (
        input  in_valid, x1, x2, x3, out_ready,
        output in_ready, out_valid, out, out_err
    );
endinterface

// File: rtl/rns_reverse_converter_pipe.sv
// RNS {2^N+1, 2^N, 2^N-1} to 3N-bit binary reverse converter, three register stages.
// Latency: 3 cycles from input accept to out_valid; one result per cycle sustained.
// Backpressure: each stage holds when the next is full and not draining; in_ready follows out_ready combinationally.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, discards everything in flight
//   bus  slave modport: in_valid/in_ready/x1/x2/x3 in, out_valid/out_ready/out/out_err out
//
// X = x2 + 2^N * Y with Y in [0, 2^(2N)-1). Combining the two odd moduli by CRT gives
//   Y = -(2^N-1)*2^(N-1)*x1 - 2^N*x2 + (2^N+1)*2^(N-1)*x3   mod 2^(2N)-1
// and since multiplying by a power of two modulo 2^(2N)-1 is a rotation, every term
// is built from wiring plus one small subtract.
module rns_reverse_converter_pipe #(
    parameter int N = 3
) (
    input  logic clk,
    input  logic rst,
    rns_reverse_converter_pipe_if.slave bus
);

    localparam int             W      = 2 * N;
    localparam int             ROT    = N - 1;
    localparam logic [N:0]     X1_MAX = {1'b1, {N{1'b0}}};
    localparam logic [N-1:0]   ONE_N  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};

    // Addition modulo 2^W-1: the carry out wraps back into bit 0. The result
    // may be all-ones, the redundant encoding of zero.
    function automatic logic [W-1:0] eac_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W-1:0] + (s[W] ? ONE_W : '0);
    endfunction

    // ---------------- stage control ----------------
    logic s1_vld_q, s1_vld_d;
    logic s2_vld_q, s2_vld_d;
    logic s3_vld_q, s3_vld_d;
    logic s1_load, s2_load, s3_load;

    assign s3_load      = s2_vld_q & (~s3_vld_q | bus.out_ready);
    assign s2_load      = s1_vld_q & (~s2_vld_q | s3_load);
    assign bus.in_ready = ~s1_vld_q | s2_load;
    assign s1_load      = bus.in_valid & bus.in_ready;

    // ---------------- S1 term generation ----------------
    logic [N-1:0]   x1_lo;
    logic [W-1:0]   c1;
    logic [2*W-1:0] a1_dbl;
    logic [2*W-1:0] a3_dbl;
    logic [W-1:0]   a1_in, a2_in, a3_in;
    logic           err_in;

    assign x1_lo  = bus.x1[N-1:0];
    assign err_in = bus.x1 > X1_MAX;
    // -(2^N-1)*x1 mod 2^W-1 for x1 in [1, 2^N] is {-x1, x1-1} as two N-bit
    // fields; x1 = 0 would give 2^N-1 in that form, so it is forced to zero.
    assign c1     = (bus.x1 == '0) ? '0 : {~x1_lo + ONE_N, x1_lo - ONE_N};
    // Rotate left by N-1 == multiply by 2^(N-1) mod 2^W-1.
    assign a1_dbl = {c1, c1} << ROT;
    assign a1_in  = a1_dbl[2*W-1:W];
    // -2^N*x2 is the one's complement of {x2, 0}.
    assign a2_in  = {~bus.x2, {N{1'b1}}};
    // (2^N+1)*x3 is {x3, x3}; x3 = 2^N-1 yields all-ones, i.e. zero.
    assign a3_dbl = {bus.x3, bus.x3, bus.x3, bus.x3} << ROT;
    assign a3_in  = a3_dbl[2*W-1:W];

    // ---------------- pipeline registers ----------------
    logic [N-1:0]   s1_x2_q, s1_x2_d;
    logic           s1_err_q, s1_err_d;
    logic [W-1:0]   s1_a1_q, s1_a1_d;
    logic [W-1:0]   s1_a2_q, s1_a2_d;
    logic [W-1:0]   s1_a3_q, s1_a3_d;

    logic [W-1:0]   s2_psum_q, s2_psum_d;
    logic [W-1:0]   s2_a1_q, s2_a1_d;
    logic [N-1:0]   s2_x2_q, s2_x2_d;
    logic           s2_err_q, s2_err_d;

    logic [3*N-1:0] s3_out_q, s3_out_d;
    logic           s3_err_q, s3_err_d;

    logic [W-1:0]   y_raw, y_norm;

    assign y_raw  = eac_add(s2_a1_q, s2_psum_q);
    assign y_norm = (&y_raw) ? '0 : y_raw;

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s2_vld_d  = s2_vld_q;
        s3_vld_d  = s3_vld_q;
        s1_x2_d   = s1_x2_q;
        s1_err_d  = s1_err_q;
        s1_a1_d   = s1_a1_q;
        s1_a2_d   = s1_a2_q;
        s1_a3_d   = s1_a3_q;
        s2_psum_d = s2_psum_q;
        s2_a1_d   = s2_a1_q;
        s2_x2_d   = s2_x2_q;
        s2_err_d  = s2_err_q;
        s3_out_d  = s3_out_q;
        s3_err_d  = s3_err_q;

        if (s1_load) begin
            s1_vld_d = 1'b1;
            s1_x2_d  = bus.x2;
            s1_err_d = err_in;
            s1_a1_d  = a1_in;
            s1_a2_d  = a2_in;
            s1_a3_d  = a3_in;
        end else if (s2_load) begin
            s1_vld_d = 1'b0;
        end

        if (s2_load) begin
            s2_vld_d  = 1'b1;
            s2_psum_d = eac_add(s1_a2_q, s1_a3_q);
            s2_a1_d   = s1_a1_q;
            s2_x2_d   = s1_x2_q;
            s2_err_d  = s1_err_q;
        end else if (s3_load) begin
            s2_vld_d = 1'b0;
        end

        if (s3_load) begin
            s3_vld_d = 1'b1;
            s3_out_d = s2_err_q ? '0 : {y_norm, s2_x2_q};
            s3_err_d = s2_err_q;
        end else if (bus.out_ready) begin
            s3_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s3_vld_q  <= 1'b0;
            s1_x2_q   <= '0;
            s1_err_q  <= 1'b0;
            s1_a1_q   <= '0;
            s1_a2_q   <= '0;
            s1_a3_q   <= '0;
            s2_psum_q <= '0;
            s2_a1_q   <= '0;
            s2_x2_q   <= '0;
            s2_err_q  <= 1'b0;
            s3_out_q  <= '0;
            s3_err_q  <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s2_vld_q  <= s2_vld_d;
            s3_vld_q  <= s3_vld_d;
            s1_x2_q   <= s1_x2_d;
            s1_err_q  <= s1_err_d;
            s1_a1_q   <= s1_a1_d;
            s1_a2_q   <= s1_a2_d;
            s1_a3_q   <= s1_a3_d;
            s2_psum_q <= s2_psum_d;
            s2_a1_q   <= s2_a1_d;
            s2_x2_q   <= s2_x2_d;
            s2_err_q  <= s2_err_d;
            s3_out_q  <= s3_out_d;
            s3_err_q  <= s3_err_d;
        end
    end

    assign bus.out_valid = s3_vld_q;
    assign bus.out       = s3_out_q;
    assign bus.out_err   = s3_err_q;

endmodule

// File: tb/tb_rns_reverse_converter_pipe.sv
// Bench for the RNS reverse converter: one N=3 and one N=4 instance on a shared clock/reset.
// Inputs change 1 ns after the rising edge, outputs are sampled 1-2 ns after it.
// A select bit routes the common stimulus to one instance; the other idles with out_ready high.
module tb_rns_reverse_converter_pipe;

    logic clk;
    logic rst;

    logic        sel4;
    logic        in_valid;
    logic [4:0]  x1;
    logic [3:0]  x2;
    logic [3:0]  x3;
    logic        out_ready;

    logic        m_in_ready;
    logic        m_out_valid;
    logic [11:0] m_out;
    logic        m_err;

    int n_vec;
    int n_fail;

    rns_reverse_converter_pipe_if #(.N(3)) b3 ();
    rns_reverse_converter_pipe_if #(.N(4)) b4 ();

    rns_reverse_converter_pipe #(.N(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
    rns_reverse_converter_pipe #(.N(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

    assign b3.in_valid  = in_valid & ~sel4;
    assign b3.x1        = x1[3:0];
    assign b3.x2        = x2[2:0];
    assign b3.x3        = x3[2:0];
    assign b3.out_ready = out_ready | sel4;

    assign b4.in_valid  = in_valid & sel4;
    assign b4.x1        = x1;
    assign b4.x2        = x2;
    assign b4.x3        = x3;
    assign b4.out_ready = out_ready | ~sel4;

    assign m_in_ready  = sel4 ? b4.in_ready  : b3.in_ready;
    assign m_out_valid = sel4 ? b4.out_valid : b3.out_valid;
    assign m_out       = sel4 ? b4.out       : {3'b000, b3.out};
    assign m_err       = sel4 ? b4.out_err   : b3.out_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One triple into an empty pipe with out_ready high; checks accept, latency,
    // value and that the result is presented for exactly one cycle.
    task automatic send_one(input string name, input bit n4, input int a1, input int a2,
                            input int a3, input int exp_out, input bit exp_err);
        int lat;
        sel4 = n4; out_ready = 1'b1;
        x1 = 5'(a1); x2 = 4'(a2); x3 = 4'(a3); in_valid = 1'b1;
        #1;
        n_vec++;
        if (m_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s accept: in_ready=%b want 1", name, m_in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (m_out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        n_vec++;
        if (lat != 3) begin
            n_fail++; $display("FAIL %s latency: got %0d cycles want 3", name, lat);
        end
        n_vec++;
        if (m_out !== 12'(exp_out) || m_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s value: out=%0d err=%b want out=%0d err=%b", name, m_out, m_err, exp_out, exp_err);
        end
        @(posedge clk); #1;
        n_vec++;
        if (m_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s duplicate: out_valid=%b want 0", name, m_out_valid);
        end
    endtask

    // Streams n_items through the selected instance with in_valid/out_ready
    // duty cycles pin/pout (percent). Expected results come from the forward
    // map X -> (X mod m1, X mod m2, X mod m3), so each triple's answer is X.
    task automatic run_stream(input string name, input bit n4, input int n_items, input int pin,
                              input int pout, input bit sweep, output int cycles);
        int nb, m1, m2, m3, mm, gen, popped, inflight, limit, xv;
        logic [12:0] expq[$];
        logic [12:0] cur_exp, e;
        logic [4:0]  cx1;
        logic [3:0]  cx2, cx3;
        bit have, prev_stall, exp_rdy;
        logic [11:0] prev_out;
        logic prev_err;
        nb = n4 ? 4 : 3;
        m2 = 1 << nb; m1 = m2 + 1; m3 = m2 - 1;
        mm = m2 * ((1 << (2 * nb)) - 1);
        gen = 0; popped = 0; inflight = 0; have = 0; prev_stall = 0;
        prev_out = '0; prev_err = 1'b0; cur_exp = '0; cx1 = '0; cx2 = '0; cx3 = '0;
        limit = n_items * 12 + 100;
        sel4 = n4; cycles = 0;
        while (popped < n_items && cycles < limit) begin
            if (!have && gen < n_items) begin
                xv = sweep ? gen : int'($urandom_range(0, mm - 1));
                cx2 = 4'(xv % m2);
                cx3 = 4'(xv % m3);
                if (!sweep && $urandom_range(0, 15) == 0) begin
                    cx1 = 5'($urandom_range(m2 + 1, 2 * m2 - 1));
                    cur_exp = {1'b1, 12'd0};
                end else begin
                    cx1 = 5'(xv % m1);
                    if (!sweep && cx3 == 4'd0 && $urandom_range(0, 1) == 1) cx3 = 4'(m3);
                    cur_exp = {1'b0, 12'(xv)};
                end
                have = 1; gen++;
            end
            in_valid  = have && ($urandom_range(0, 99) < pin);
            x1 = cx1; x2 = cx2; x3 = cx3;
            out_ready = ($urandom_range(0, 99) < pout);
            #1;
            exp_rdy = !(inflight == 3 && !out_ready);
            n_vec++;
            if (m_in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL %s in_ready: got %b want %b (in flight %0d)", name, m_in_ready, exp_rdy, inflight);
            end
            if (prev_stall) begin
                n_vec++;
                if (m_out_valid !== 1'b1 || m_out !== prev_out || m_err !== prev_err) begin
                    n_fail++;
                    $display("FAIL %s stall hold: valid=%b out=%0d err=%b want valid=1 out=%0d err=%b",
                             name, m_out_valid, m_out, m_err, prev_out, prev_err);
                end
            end
            if (m_out_valid === 1'b1 && out_ready) begin
                n_vec++;
                if (expq.size() == 0) begin
                    n_fail++; $display("FAIL %s spurious output: out=%0d want none", name, m_out);
                end else begin
                    e = expq.pop_front();
                    if ({m_err, m_out} !== e) begin
                        n_fail++;
                        $display("FAIL %s result #%0d: out=%0d err=%b want out=%0d err=%b",
                                 name, popped, m_out, m_err, e[11:0], e[12]);
                    end
                    popped++; inflight--;
                end
            end
            if (in_valid && m_in_ready === 1'b1) begin
                expq.push_back(cur_exp);
                have = 0; inflight++;
            end
            prev_stall = (m_out_valid === 1'b1) && !out_ready;
            prev_out = m_out; prev_err = m_err;
            @(posedge clk); #1;
            cycles++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_vec++;
        if (popped != n_items) begin
            n_fail++; $display("FAIL %s completion: got %0d results want %0d", name, popped, n_items);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel4 = 1'b0;
        x1 = '0; x2 = '0; x3 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (b3.out_valid !== 1'b0 || b3.out !== 9'd0 || b3.out_err !== 1'b0) begin
            n_fail++; $display("FAIL reset n3: valid=%b out=%0d err=%b want 0 0 0", b3.out_valid, b3.out, b3.out_err);
        end
        n_vec++;
        if (b4.out_valid !== 1'b0 || b4.out !== 12'd0 || b4.out_err !== 1'b0) begin
            n_fail++; $display("FAIL reset n4: valid=%b out=%0d err=%b want 0 0 0", b4.out_valid, b4.out, b4.out_err);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (b3.in_ready !== 1'b1 || b4.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset in_ready: n3=%b n4=%b want 1 1", b3.in_ready, b4.in_ready);
        end
    endtask

    task automatic test_single();
        send_one("single", 0, 1, 4, 2, 100, 0);
    endtask

    task automatic test_boundaries();
        send_one("zero",      0, 0, 0, 0, 0,   0);
        send_one("max_n3",    0, 8, 7, 6, 503, 0);
        send_one("alias_x3",  0, 5, 6, 7, 14,  0);
        send_one("plain_x3",  0, 5, 6, 0, 14,  0);
    endtask

    task automatic test_error();
        send_one("err_x1",    0, 12, 0, 0, 0,   1);
        send_one("after_err", 0, 1,  4, 2, 100, 0);
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_stream("sweep", 0, 504, 100, 100, 1, cyc);
        n_vec++;
        if (cyc != 507) begin
            n_fail++; $display("FAIL sweep throughput: %0d cycles want 507", cyc);
        end
    endtask

    task automatic test_n4();
        int cyc;
        send_one("max_n4",   1, 16, 15, 14, 4079, 0);
        send_one("mid_n4",   1, 1,  4,  2,  1412, 0);
        run_stream("rand_n4", 1, 300, 100, 100, 0, cyc);
        run_stream("bp_n4",   1, 300, 50,  50,  0, cyc);
    endtask

    task automatic test_backpressure();
        int cyc;
        run_stream("bp_n3", 0, 10000, 50, 50, 0, cyc);
    endtask

    task automatic test_reset_inflight();
        int t1[3] = '{1, 0, 8};
        int t2[3] = '{4, 0, 7};
        int t3[3] = '{2, 0, 6};
        bit stale;
        sel4 = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x1 = 5'(t1[i]); x2 = 4'(t2[i]); x3 = 4'(t3[i]); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (m_out_valid !== 1'b1 || m_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL full: out_valid=%b in_ready=%b want 1 0", m_out_valid, m_in_ready);
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (m_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL full release: in_ready=%b want 1", m_in_ready);
        end
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (m_out_valid !== 1'b0 || m_out !== 12'd0) begin
            n_fail++; $display("FAIL midreset: out_valid=%b out=%0d want 0 0", m_out_valid, m_out);
        end
        rst = 1'b0; out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (m_out_valid !== 1'b0) stale = 1;
        end
        n_vec++;
        if (stale) begin
            n_fail++; $display("FAIL stale after reset: out_valid seen 1 want 0");
        end
        send_one("post_reset", 0, 5, 6, 7, 14, 0);
    endtask

    initial begin
        n_vec = 0; n_fail = 0;
        rst = 1'b1; sel4 = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x1 = '0; x2 = '0; x3 = '0;
        test_reset();
        test_single();
        test_boundaries();
        test_error();
        test_back_to_back();
        test_n4();
        test_backpressure();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
